// File: rtl/pipeline_hazard_ctrl_pkg.sv
// rtl/pipeline_hazard_ctrl_pkg.sv - shared types and constants for the hazard controller
package pipeline_hazard_ctrl_pkg;

  // Controller state encoding
  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_DRAIN  = 2'b01,
    ST_HALTED = 2'b10
  } state_e;

  localparam int HC_REG_W        = 4;
  localparam int HC_DRAIN_CYCLES = 3;
  localparam int HC_CNT_W        = 16;

  // Instruction word the IF/ID register loads when fd_flush is asserted
  localparam logic [15:0] NOP_INSTR = 16'h0000;

  // One bundle of pipeline-register controls, MSB first
  typedef struct packed {
    logic pc_wen;
    logic fd_wen;
    logic fd_flush;
    logic dx_wen;
    logic dx_flush;
    logic xm_wen;
    logic mw_wen;
    logic mw_flush;
  } stage_ctrl_t;

  // Everything advances, nothing squashed
  localparam stage_ctrl_t CTRL_IDLE    = 8'b1101_0110;
  // Hold PC and IF/ID, inject a bubble into ID/EX
  localparam stage_ctrl_t CTRL_BUBBLE  = 8'b0001_1110;
  // PC takes the target, wrong-path fetch discarded
  localparam stage_ctrl_t CTRL_BRANCH  = 8'b1111_0110;
  // PC held, NOP fed into IF/ID, downstream advances
  localparam stage_ctrl_t CTRL_REFETCH = 8'b0111_0110;
  // Data memory not ready: freeze up to EX/MEM, bubble into MEM/WB
  localparam stage_ctrl_t CTRL_FREEZE  = 8'b0000_0011;
  // Core halted: nothing moves
  localparam stage_ctrl_t CTRL_HALT    = 8'b0000_0000;

endpackage

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
// rtl/pipeline_hazard_ctrl_load_use_detect.sv - combinational load-use hazard comparator
module load_use_detect
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int REG_W = HC_REG_W
) (
  input  logic [REG_W-1:0] i_rs,
  input  logic [REG_W-1:0] i_rt,
  input  logic             i_uses_rt,
  input  logic             i_x_mem_read,
  input  logic [REG_W-1:0] i_x_dest,
  output logic             o_lu
);

  logic w_dest_live;
  logic w_rs_hit;
  logic w_rt_hit;

  // Register 0 is hardwired, so a load targeting it never creates a dependency
  assign w_dest_live = i_x_mem_read && (i_x_dest != '0);
  assign w_rs_hit    = (i_x_dest == i_rs);
  assign w_rt_hit    = i_uses_rt && (i_x_dest == i_rt);
  assign o_lu        = w_dest_live && (w_rs_hit || w_rt_hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - pipeline register sequencing, hazard and halt-drain control
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int REG_W        = HC_REG_W,
  parameter int DRAIN_CYCLES = HC_DRAIN_CYCLES,
  parameter int CNT_W        = HC_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] D_Operand1,
  input  logic [REG_W-1:0] D_Operand2_Fw,
  input  logic             D_uses_op2,
  input  logic             D_hlt,
  input  logic             D_branch_taken,
  input  logic             X_MemRead,
  input  logic [REG_W-1:0] X_Destination,
  input  logic             imem_stall,
  input  logic             dmem_stall,
  output logic             pc_wen,
  output logic             fd_wen,
  output logic             fd_flush,
  output logic             dx_wen,
  output logic             dx_flush,
  output logic             xm_wen,
  output logic             mw_wen,
  output logic             mw_flush,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int DW = $clog2(DRAIN_CYCLES + 1);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [DW-1:0]    r_drain_cnt;
  logic [DW-1:0]    w_drain_cnt_nxt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic             r_halted;
  logic             w_lu;
  stage_ctrl_t      w_ctrl;

  load_use_detect #(
    .REG_W (REG_W)
  ) u_load_use_detect (
    .i_rs         (D_Operand1),
    .i_rt         (D_Operand2_Fw),
    .i_uses_rt    (D_uses_op2),
    .i_x_mem_read (X_MemRead),
    .i_x_dest     (X_Destination),
    .o_lu         (w_lu)
  );

  // Next-state, drain counter and stage controls; priority order inside RUN matters
  always_comb begin
    w_ctrl          = CTRL_IDLE;
    w_state_nxt     = r_state;
    w_drain_cnt_nxt = r_drain_cnt;
    case (r_state)
      ST_RUN: begin
        if (dmem_stall) begin
          w_ctrl = CTRL_FREEZE;
        end else if (w_lu) begin
          // A same-cycle branch is dropped; decode re-resolves it after the bubble
          w_ctrl = CTRL_BUBBLE;
        end else if (D_branch_taken) begin
          // Beats imem_stall: the stalled fetch is wrong-path anyway
          w_ctrl = CTRL_BRANCH;
        end else if (D_hlt) begin
          w_ctrl          = CTRL_REFETCH;
          w_state_nxt     = ST_DRAIN;
          w_drain_cnt_nxt = DW'(DRAIN_CYCLES);
        end else if (imem_stall) begin
          w_ctrl = CTRL_REFETCH;
        end
      end
      ST_DRAIN: begin
        if (dmem_stall) begin
          w_ctrl = CTRL_FREEZE;
        end else begin
          // Decode only ever sees NOPs here, so no load-use check is needed
          w_ctrl          = CTRL_REFETCH;
          w_drain_cnt_nxt = r_drain_cnt - DW'(1);
          if (r_drain_cnt <= DW'(1)) begin
            w_state_nxt = ST_HALTED;
          end
        end
      end
      ST_HALTED: begin
        w_ctrl = CTRL_HALT;
      end
      default: begin
        w_state_nxt = ST_RUN;
      end
    endcase
  end

  // State and drain counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_RUN;
      r_drain_cnt <= '0;
      r_halted    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_drain_cnt <= w_drain_cnt_nxt;
      r_halted    <= (w_state_nxt == ST_HALTED);
    end
  end

  // Saturating count of RUN cycles in which the PC did not advance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if ((r_state == ST_RUN) && !w_ctrl.pc_wen && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign pc_wen    = w_ctrl.pc_wen;
  assign fd_wen    = w_ctrl.fd_wen;
  assign fd_flush  = w_ctrl.fd_flush;
  assign dx_wen    = w_ctrl.dx_wen;
  assign dx_flush  = w_ctrl.dx_flush;
  assign xm_wen    = w_ctrl.xm_wen;
  assign mw_wen    = w_ctrl.mw_wen;
  assign mw_flush  = w_ctrl.mw_flush;
  assign halted    = r_halted;
  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - self-checking bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;

  // Expected control bundles: {pc,fd,fd_flush,dx,dx_flush,xm,mw,mw_flush}
  localparam logic [7:0] E_IDLE = 8'b1101_0110;
  localparam logic [7:0] E_BUB  = 8'b0001_1110;
  localparam logic [7:0] E_BR   = 8'b1111_0110;
  localparam logic [7:0] E_REF  = 8'b0111_0110;
  localparam logic [7:0] E_FRZ  = 8'b0000_0011;
  localparam logic [7:0] E_HALT = 8'b0000_0000;

  typedef struct {
    logic [3:0] op1;
    logic [3:0] op2;
    logic       uses2;
    logic       br;
    logic       mrd;
    logic [3:0] dst;
    logic       imem;
    logic       dmem;
    logic [7:0] exp;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic [3:0]  D_Operand1;
  logic [3:0]  D_Operand2_Fw;
  logic        D_uses_op2;
  logic        D_hlt;
  logic        D_branch_taken;
  logic        X_MemRead;
  logic [3:0]  X_Destination;
  logic        imem_stall;
  logic        dmem_stall;
  logic        pc_wen, fd_wen, fd_flush, dx_wen, dx_flush, xm_wen, mw_wen, mw_flush;
  logic        halted;
  logic [15:0] stall_cnt;
  logic [7:0]  w_outs;

  int          n_tests;
  int          n_fails;
  int          exp_cnt;
  logic [7:0]  sb_q[$];
  vec_t        vecs[14];

  assign w_outs = {pc_wen, fd_wen, fd_flush, dx_wen, dx_flush, xm_wen, mw_wen, mw_flush};

  pipeline_hazard_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .D_Operand1     (D_Operand1),
    .D_Operand2_Fw  (D_Operand2_Fw),
    .D_uses_op2     (D_uses_op2),
    .D_hlt          (D_hlt),
    .D_branch_taken (D_branch_taken),
    .X_MemRead      (X_MemRead),
    .X_Destination  (X_Destination),
    .imem_stall     (imem_stall),
    .dmem_stall     (dmem_stall),
    .pc_wen         (pc_wen),
    .fd_wen         (fd_wen),
    .fd_flush       (fd_flush),
    .dx_wen         (dx_wen),
    .dx_flush       (dx_flush),
    .xm_wen         (xm_wen),
    .mw_wen         (mw_wen),
    .mw_flush       (mw_flush),
    .halted         (halted),
    .stall_cnt      (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(input logic [3:0] op1, input logic [3:0] op2, input logic uses2,
                              input logic br, input logic mrd, input logic [3:0] dst,
                              input logic imem, input logic dmem, input logic [7:0] exp);
    vec_t v;
    v.op1 = op1; v.op2 = op2; v.uses2 = uses2; v.br = br; v.mrd = mrd;
    v.dst = dst; v.imem = imem; v.dmem = dmem; v.exp = exp;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    D_Operand1 = 4'd0; D_Operand2_Fw = 4'd0; D_uses_op2 = 1'b0; D_hlt = 1'b0;
    D_branch_taken = 1'b0; X_MemRead = 1'b0; X_Destination = 4'd0;
    imem_stall = 1'b0; dmem_stall = 1'b0;
  endtask

  task automatic drive_vec(input vec_t v);
    D_Operand1 = v.op1; D_Operand2_Fw = v.op2; D_uses_op2 = v.uses2; D_hlt = 1'b0;
    D_branch_taken = v.br; X_MemRead = v.mrd; X_Destination = v.dst;
    imem_stall = v.imem; dmem_stall = v.dmem;
    sb_q.push_back(v.exp);
  endtask

  // Pop the expectation queued when the stimulus was driven and compare at negedge
  task automatic sample_ctrl(input string name);
    logic [7:0] e;
    @(negedge clk);
    if (sb_q.size() == 0) begin
      chk({name, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      chk(name, {24'd0, w_outs}, {24'd0, e});
    end
  endtask

  // Called at posedge+1; leaves the bench mid-cycle with reset released
  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    exp_cnt = 0;
  endtask

  task automatic run_halt(input string name, input int ds, input int dl, input int exp_edge);
    int halt_edge;
    @(posedge clk); #1;
    do_reset();
    halt_edge = 0;
    for (int c = 0; c < 20 && halt_edge == 0; c++) begin
      D_hlt = 1'b1;
      dmem_stall = (c >= ds) && (c < ds + dl);
      if (c == 0)          sb_q.push_back(E_REF);
      else if (dmem_stall) sb_q.push_back(E_FRZ);
      else                 sb_q.push_back(E_REF);
      sample_ctrl({name, "_ctrl"});
      @(posedge clk); #1;
      if (halted) halt_edge = c + 1;
    end
    chk({name, "_halt_edge"}, halt_edge, exp_edge);
    dmem_stall = 1'b0;
    D_branch_taken = 1'b1;
    for (int c = 0; c < 3; c++) begin
      sb_q.push_back(E_HALT);
      sample_ctrl({name, "_halted_ctrl"});
      @(posedge clk); #1;
      chk({name, "_halted_sticky"}, {31'd0, halted}, 32'd1);
    end
    chk({name, "_stall_cnt"}, {16'd0, stall_cnt}, 32'd1);
    idle_inputs();
  endtask

  initial begin
    n_tests = 0;
    n_fails = 0;
    exp_cnt = 0;
    idle_inputs();
    rst_n = 1'b0;

    //        op1 op2 u2 br mrd dst imem dmem exp
    vecs[0]  = mk(4'd1,  4'd2, 1, 0, 0, 4'd0,  0, 0, E_IDLE);
    vecs[1]  = mk(4'd3,  4'd0, 0, 0, 1, 4'd3,  0, 0, E_BUB);
    vecs[2]  = mk(4'd0,  4'd0, 1, 0, 1, 4'd0,  0, 0, E_IDLE);
    vecs[3]  = mk(4'd1,  4'd5, 1, 0, 1, 4'd5,  0, 0, E_BUB);
    vecs[4]  = mk(4'd1,  4'd5, 0, 0, 1, 4'd5,  0, 0, E_IDLE);
    vecs[5]  = mk(4'd7,  4'd0, 0, 1, 1, 4'd7,  0, 0, E_BUB);
    vecs[6]  = mk(4'd7,  4'd0, 0, 1, 0, 4'd7,  0, 0, E_BR);
    vecs[7]  = mk(4'd0,  4'd0, 0, 1, 0, 4'd0,  1, 0, E_BR);
    vecs[8]  = mk(4'd0,  4'd0, 0, 0, 0, 4'd0,  1, 0, E_REF);
    vecs[9]  = mk(4'd0,  4'd0, 0, 0, 0, 4'd0,  0, 1, E_FRZ);
    vecs[10] = mk(4'd3,  4'd0, 0, 1, 1, 4'd3,  1, 1, E_FRZ);
    vecs[11] = mk(4'd4,  4'd4, 1, 0, 0, 4'd4,  0, 0, E_IDLE);
    vecs[12] = mk(4'd2,  4'd0, 0, 0, 1, 4'd2,  1, 0, E_BUB);
    vecs[13] = mk(4'd15, 4'd0, 0, 0, 1, 4'd15, 0, 0, E_BUB);

    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    sb_q.push_back(E_IDLE);
    sample_ctrl("reset_ctrl");
    chk("reset_halted", {31'd0, halted}, 32'd0);
    chk("reset_stall_cnt", {16'd0, stall_cnt}, 32'd0);

    @(posedge clk); #1;
    for (int i = 0; i < 14; i++) begin
      drive_vec(vecs[i]);
      sample_ctrl($sformatf("vec%0d_ctrl", i));
      @(posedge clk); #1;
      if (!vecs[i].exp[7]) exp_cnt++;
      chk($sformatf("vec%0d_stall_cnt", i), {16'd0, stall_cnt}, exp_cnt);
    end
    idle_inputs();

    run_halt("halt_plain", 0, 0, 4);
    run_halt("halt_dmem", 1, 2, 6);

    // Asynchronous reset from DRAIN, mid-cycle with no clock edge
    @(posedge clk); #1;
    do_reset();
    D_hlt = 1'b1;
    @(posedge clk); #1;
    D_hlt = 1'b0;
    chk("drain_entry_stall_cnt", {16'd0, stall_cnt}, 32'd1);
    chk("drain_entry_pc_wen", {31'd0, pc_wen}, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_ctrl", {24'd0, w_outs}, {24'd0, E_IDLE});
    chk("async_rst_stall_cnt", {16'd0, stall_cnt}, 32'd0);
    chk("async_rst_halted", {31'd0, halted}, 32'd0);
    rst_n = 1'b1;

    // Stall counter saturation under a long instruction-memory stall
    @(posedge clk); #1;
    do_reset();
    imem_stall = 1'b1;
    repeat (65534) @(posedge clk);
    #1;
    chk("sat_fffe", {16'd0, stall_cnt}, 32'h0000_FFFE);
    @(posedge clk); #1;
    chk("sat_ffff", {16'd0, stall_cnt}, 32'h0000_FFFF);
    repeat (5) @(posedge clk);
    #1;
    chk("sat_hold", {16'd0, stall_cnt}, 32'h0000_FFFF);
    sb_q.push_back(E_REF);
    sample_ctrl("sat_ctrl");
    idle_inputs();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Sequences the four pipeline registers of the 16-bit core: IF/ID, ID/EX, EX/MEM and MEM/WB.
- Generates per-stage write-enable and flush (bubble) controls from the following events:
  - load-use hazards;
  - taken branches;
  - instruction- and data-memory stalls;
  - halt.
- Runs a drain FSM so that HLT retires only after all older instructions have written back.
- Sits beside the pipeline registers. Its outputs drive their wen and flush inputs and the PC wen.

Parameters:
- REG_W, 4, width of register specifiers.
- DRAIN_CYCLES, 3, cycles for HLT to travel from ID/EX to the MEM/WB output.
- CNT_W, 16, width of the stall-cycle counter.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset.
- D_Operand1  in  REG_W  rs of the instruction in decode.
- D_Operand2_Fw  in  REG_W  rt of the instruction in decode.
- D_uses_op2  in  1  decode instruction reads rt.
- D_hlt  in  1  decode instruction is HLT.
- D_branch_taken  in  1  branch resolved taken in decode.
- X_MemRead  in  1  the instruction in EX is a load.
- X_Destination  in  REG_W  destination register of the instruction in EX.
- imem_stall  in  1  instruction memory is not ready this cycle.
- dmem_stall  in  1  data memory is not ready this cycle.
- pc_wen  out  1  PC register write enable.
- fd_wen  out  1  IF/ID write enable.
- fd_flush  out  1  load NOP into IF/ID.
- dx_wen  out  1  ID/EX write enable.
- dx_flush  out  1  clear ID/EX control bits (bubble).
- xm_wen  out  1  EX/MEM write enable.
- mw_wen  out  1  MEM/WB write enable.
- mw_flush  out  1  bubble into MEM/WB.
- halted  out  1  core halted.
- stall_cnt  out  CNT_W  cycles in which pc_wen was 0 while the FSM was in RUN.

Behaviour:
- Clock and reset:
  - One clock, clk.
  - Reset rst_n is asynchronous and active-low.
  - In reset: state=RUN, drain_cnt=0, stall_cnt=0, halted=0.
  - With no hazard inputs, the reset outputs are all wen=1 and all flush=0.
- Stage-control outputs are combinational from state plus inputs; there is no added latency. halted is registered.
- Load-use hazard (lu): X_MemRead & X_Destination!=0 & (X_Destination==D_Operand1 | (D_uses_op2 & X_Destination==D_Operand2_Fw)).
- Priority in RUN, highest first:
  1. dmem_stall: pc_wen=fd_wen=dx_wen=xm_wen=0, mw_flush=1, mw_wen=1. All other outputs are inactive.
  2. lu: pc_wen=fd_wen=0, dx_flush=1, xm_wen=mw_wen=1. This is a one-cycle bubble. A branch in decode in the same cycle is ignored and re-evaluated next cycle.
  3. D_branch_taken: pc_wen=1 (target), fd_flush=1, everything else enabled.
  4. D_hlt: go to DRAIN, load drain_cnt=DRAIN_CYCLES. This cycle: pc_wen=0, fd_flush=1, dx_wen=1 (HLT enters ID/EX).
  5. imem_stall: pc_wen=0, fd_flush=1, downstream enabled.
  6. Otherwise all wen=1 and all flush=0.
- DRAIN state:
  - pc_wen=0 and fd_flush=1 every cycle. Later stages advance normally.
  - lu is impossible, since decode holds a NOP.
  - dmem_stall freezes stages as in RUN and also freezes drain_cnt.
  - drain_cnt decrements on each non-frozen cycle. When it reaches 1 and decrements, go to HALTED on the next edge.
- HALTED state:
  - All wen=0, all flush=0, halted=1.
  - HALTED is sticky until rst_n is asserted.
- Reset asserted in DRAIN or HALTED returns the block to RUN immediately (asynchronous).
- stall_cnt:
  - Increments by 1 on each edge where state=RUN and pc_wen=0.
  - Saturates at all ones and never wraps.
  - The cycle in which HLT enters ID/EX counts.
- Simultaneous imem_stall and branch taken: the branch wins. The PC loads the target and the fetch is discarded.
- X_Destination==0 never causes a stall, because register 0 is hardwired.

Decomposition:
- Shared core package holds:
  - state encoding RUN=2'b00, DRAIN=2'b01, HALTED=2'b10;
  - DRAIN_CYCLES default;
  - REG_W;
  - the NOP encoding used by fd_flush.
- One sub-module, load_use_detect: a purely combinational comparator producing lu.
- The FSM, drain counter and stall counter stay in pipeline_hazard_ctrl.

Test Plan:
- Reset then idle inputs -> all wen=1, flush=0, halted=0, stall_cnt=0. Assert rst_n=0 mid-cycle -> outputs reset without waiting for a clk edge.
- X_MemRead=1, X_Destination=3, D_Operand1=3 for one cycle -> pc_wen=0, fd_wen=0, dx_flush=1, stall_cnt=1. Same with X_Destination=0 -> no stall.
- lu and D_branch_taken together -> bubble only, fd_flush=0. Next cycle (lu low) with D_branch_taken=1 -> pc_wen=1, fd_flush=1.
- D_hlt=1 with no stalls -> DRAIN for 3 cycles, then halted=1 on the 4th edge with all wen=0. Holding D_hlt high afterwards has no effect.
- D_hlt, then dmem_stall high for 2 cycles during DRAIN -> halted rises 2 cycles later than in the no-stall case. mw_flush=1 during the stall.
- Force 65540 cycles of imem_stall -> stall_cnt=16'hFFFF and stays there.
